// File: rtl/ped_crossing_if.sv
// Bus between the traffic-light sequencer / pedestrian push-button side
// (master) and the pedestrian-crossing controller (slave).
interface ped_crossing_if #(
    parameter int CW = 4
) ();
    logic [2:0]    light;
    logic          ped_btn;
    logic          walk;
    logic          dont_walk;
    logic          req_pending;
    logic [CW-1:0] countdown;
    logic          fault;

    modport master (
        output light, ped_btn,
        input  walk, dont_walk, req_pending, countdown, fault
    );

    modport slave (
        input  light, ped_btn,
        output walk, dont_walk, req_pending, countdown, fault
    );
endinterface

// File: rtl/ped_crossing.sv
// Pedestrian-crossing controller: latches button requests, grants a timed
// WALK phase at a red onset, follows it with a flashing clearance phase,
// aborts if red ends early and locks into FAULT on an illegal light code.
module ped_crossing #(
    parameter int WALK_CYC  = 4,
    parameter int CLEAR_CYC = 3,
    parameter int CW        = 4
) (
    input  logic            clk,
    input  logic            rst,
    ped_crossing_if.slave   bus
);
    localparam logic [2:0]    RED        = 3'b100;
    localparam logic [2:0]    GRN        = 3'b010;
    localparam logic [2:0]    YEL        = 3'b001;
    localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WALK,
        S_CLEAR,
        S_FAULT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    prev_light;
    logic          walk_q, walk_n;
    logic          dont_walk_q, dont_walk_n;
    logic          req_q, req_n;
    logic [CW-1:0] cd_q, cd_n;
    logic          fault_q, fault_n;
    logic          red_onset;

    // Only one lamp of the sequencer may be lit at a time.
    function automatic logic light_legal(input logic [2:0] l);
        return (l == RED) || (l == GRN) || (l == YEL);
    endfunction

    // Countdown decrement that holds at zero instead of wrapping.
    function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
        return (v == '0) ? v : v - CW'(1);
    endfunction

    assign red_onset = (bus.light == RED) && (prev_light != RED);

    // Next-state and next-output decode; fault check overrides everything.
    always_comb begin
        state_n     = state;
        walk_n      = walk_q;
        dont_walk_n = dont_walk_q;
        req_n       = req_q;
        cd_n        = cd_q;
        fault_n     = fault_q;

        if (!light_legal(bus.light) || state == S_FAULT) begin
            state_n     = S_FAULT;
            walk_n      = 1'b0;
            dont_walk_n = 1'b1;
            req_n       = 1'b0;
            cd_n        = '0;
            fault_n     = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    walk_n      = 1'b0;
                    dont_walk_n = 1'b1;
                    cd_n        = '0;
                    // A button coinciding with red onset only arms the request.
                    if (bus.ped_btn) begin
                        state_n = S_ARMED;
                        req_n   = 1'b1;
                    end
                end
                S_ARMED: begin
                    req_n = 1'b1;
                    if (red_onset) begin
                        state_n     = S_WALK;
                        cd_n        = WALK_LOAD;
                        req_n       = 1'b0;
                        walk_n      = 1'b1;
                        dont_walk_n = 1'b0;
                    end
                end
                S_WALK, S_CLEAR: begin
                    req_n = req_q | bus.ped_btn;
                    if (bus.light != RED) begin
                        // Red ended early: drop back safely, abort beats phase end.
                        state_n     = req_n ? S_ARMED : S_IDLE;
                        cd_n        = '0;
                        walk_n      = 1'b0;
                        dont_walk_n = 1'b1;
                    end else if (state == S_WALK) begin
                        if (cd_q == '0) begin
                            state_n     = S_CLEAR;
                            cd_n        = CLEAR_LOAD;
                            walk_n      = 1'b0;
                            dont_walk_n = 1'b0;
                        end else begin
                            cd_n = dec_sat(cd_q);
                        end
                    end else begin
                        if (cd_q == '0) begin
                            state_n     = req_n ? S_ARMED : S_IDLE;
                            dont_walk_n = 1'b1;
                        end else begin
                            cd_n        = dec_sat(cd_q);
                            dont_walk_n = ~dont_walk_q;
                        end
                    end
                end
                default: begin
                    state_n = S_FAULT;
                end
            endcase
        end
    end

    // State, light history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            prev_light  <= RED;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            req_q       <= 1'b0;
            cd_q        <= '0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_n;
            prev_light  <= bus.light;
            walk_q      <= walk_n;
            dont_walk_q <= dont_walk_n;
            req_q       <= req_n;
            cd_q        <= cd_n;
            fault_q     <= fault_n;
        end
    end

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.req_pending = req_q;
    assign bus.countdown   = cd_q;
    assign bus.fault       = fault_q;

endmodule
